// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result bundle between the E stage and the HI/LO unit.
// The master drives the issue side; the slave returns busy and the HI/LO view.
interface muldiv_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hilo_sel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] hilo_E;

   modport master (
      output start, op, rs_data, rt_data, hilo_sel,
      input  busy, hi, lo, hilo_E
   );

   modport slave (
      input  start, op, rs_data, rt_data, hilo_sel,
      output busy, hi, lo, hilo_E
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency HI/LO multiply/divide unit (5 / 10 busy cycles).
// Define MULDIV_MADD_EN to enable MADD/MSUB; otherwise ops 110/111 are no-ops.
module muldiv_unit (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;

`ifdef MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] a_q, a_n;
   logic [31:0] b_q, b_n;
   logic [2:0]  op_q, op_n;
   logic [31:0] hi_q, hi_n;
   logic [31:0] lo_q, lo_n;

   logic is_mul, is_div, is_mthi, is_mtlo;

   logic signed [63:0] sprod;
   logic [63:0] uprod;
   logic        a_neg, b_neg, div_zero;
   logic [31:0] ua, ub, ub_safe;
   logic [31:0] uq, ur, quo, rem;

   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      unique case (bus.op)
         OP_MULT, OP_MULTU: is_mul  = 1'b1;
         OP_DIV, OP_DIVU:   is_div  = 1'b1;
         OP_MTHI:           is_mthi = 1'b1;
         OP_MTLO:           is_mtlo = 1'b1;
         default:           is_mul  = MADD_EN;
      endcase
   end

   // Datapath works only on latched operands so the E-stage buses may move.
   always_comb begin
      sprod = $signed({{32{a_q[31]}}, a_q}) *
              $signed({{32{b_q[31]}}, b_q});
      uprod = {32'd0, a_q} * {32'd0, b_q};
   end

   // Sign-magnitude divide keeps 0x80000000 / -1 well defined.
   always_comb begin
      a_neg    = (op_q == OP_DIV) & a_q[31];
      b_neg    = (op_q == OP_DIV) & b_q[31];
      ua       = a_neg ? -a_q : a_q;
      ub       = b_neg ? -b_q : b_q;
      div_zero = (b_q == 32'd0);
      ub_safe  = div_zero ? 32'd1 : ub;
      uq       = ua / ub_safe;
      ur       = ua % ub_safe;
      quo      = (a_neg ^ b_neg) ? -uq : uq;
      rem      = a_neg ? -ur : ur;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a_n     = a_q;
      b_n     = b_q;
      op_n    = op_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               unique case (1'b1)
                  is_mul: begin
                     a_n     = bus.rs_data;
                     b_n     = bus.rt_data;
                     op_n    = bus.op;
                     cnt_n   = 4'd5;
                     state_n = RUN;
                  end
                  is_div: begin
                     a_n     = bus.rs_data;
                     b_n     = bus.rt_data;
                     op_n    = bus.op;
                     cnt_n   = 4'd10;
                     state_n = RUN;
                  end
                  is_mthi: hi_n = bus.rs_data;
                  is_mtlo: lo_n = bus.rs_data;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_n = IDLE;
               unique case (op_q)
                  OP_MULT:  {hi_n, lo_n} = sprod;
                  OP_MULTU: {hi_n, lo_n} = uprod;
                  OP_DIV, OP_DIVU: begin
                     if (!div_zero) begin
                        hi_n = rem;
                        lo_n = quo;
                     end
                  end
`ifdef MULDIV_MADD_EN
                  OP_MADD: {hi_n, lo_n} = {hi_q, lo_q} + sprod;
                  OP_MSUB: {hi_n, lo_n} = {hi_q, lo_q} - sprod;
`endif
                  default: ;
               endcase
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         op_q  <= 3'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         a_q   <= a_n;
         b_q   <= b_n;
         op_q  <= op_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;
   assign bus.hilo_E = bus.hilo_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO come
// from a 64-bit arithmetic model, honouring MULDIV_MADD_EN like the DUT.
module tb_muldiv_unit;
   localparam logic [2:0] MULT  = 3'd0;
   localparam logic [2:0] MULTU = 3'd1;
   localparam logic [2:0] DIV   = 3'd2;
   localparam logic [2:0] DIVU  = 3'd3;
   localparam logic [2:0] MTHI  = 3'd4;
   localparam logic [2:0] MTLO  = 3'd5;
   localparam logic [2:0] MADD  = 3'd6;
   localparam logic [2:0] MSUB  = 3'd7;

   logic clk = 1'b0;
   logic reset;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   function automatic int predict(logic [2:0] op,
                                  logic [31:0] a,
                                  logic [31:0] b);
      longint      sa;
      longint      sbv;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         MULT: begin
            p = 64'(sa * sbv);
            {m_hi, m_lo} = p;
            return 5;
         end
         MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = p;
            return 5;
         end
         DIV: begin
            if (b != 32'd0) begin
               m_lo = 32'(sa / sbv);
               m_hi = 32'(sa % sbv);
            end
            return 10;
         end
         DIVU: begin
            if (b != 32'd0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
            return 10;
         end
         MTHI: begin
            m_hi = a;
            return 0;
         end
         MTLO: begin
            m_lo = a;
            return 0;
         end
         default: begin
`ifdef MULDIV_MADD_EN
            p = 64'(sa * sbv);
            if (op == MADD) {m_hi, m_lo} = {m_hi, m_lo} + p;
            else            {m_hi, m_lo} = {m_hi, m_lo} - p;
            return 5;
`else
            return 0;
`endif
         end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int n,
                         output bit held);
      exp_t        e;
      logic [31:0] oh;
      logic [31:0] ol;
      e.cyc = predict(op, a, b);
      e.hi  = m_hi;
      e.lo  = m_lo;
      sb.push_back(e);
      oh = bus.hi;
      ol = bus.lo;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = a;
      bus.rt_data = b;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.rs_data = $urandom;
      bus.rt_data = $urandom;
      n    = 0;
      held = 1'b1;
      while (bus.busy && n < 40) begin
         if (bus.hi !== oh || bus.lo !== ol) held = 1'b0;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.start   = 1'b1;
      bus.op      = MTHI;
      bus.rs_data = 32'h1234_5678;
      bus.rt_data = 32'd0;
      bus.hilo_sel = 1'b1;
      repeat (3) @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      checks += 4;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b want=0", bus.busy);
      end
      if (bus.hi !== 32'd0) begin
         failures++;
         $display("FAIL reset_hi got=%h want=0", bus.hi);
      end
      if (bus.lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_lo got=%h want=0", bus.lo);
      end
      if (bus.hilo_E !== 32'd0) begin
         failures++;
         $display("FAIL reset_hilo_E got=%h want=0", bus.hilo_E);
      end
   endtask

   task automatic test_arith();
      logic [2:0]  t_op[12];
      logic [31:0] t_a[12];
      logic [31:0] t_b[12];
      exp_t        e;
      int          n;
      bit          held;
      t_op = '{MULT, MULTU, DIVU, DIV, DIV, MTHI,
               MTLO, MADD, MSUB, DIVU, MULT, MTLO};
      t_a  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9,
               32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd1,
               32'd3, 32'd5, 32'h8000_0000, 32'h1234_5678};
      t_b  = '{32'd3, 32'd3, 32'd7, 32'd2,
               32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1,
               32'hFFFF_FFFB, 32'd0, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 12; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], n, held);
         e = sb.pop_front();
         checks += 6;
         if (n !== e.cyc) begin
            failures++;
            $display("FAIL arith%0d_busy got=%0d want=%0d", i, n, e.cyc);
         end
         if (!held) begin
            failures++;
            $display("FAIL arith%0d_hold got=changed want=held", i);
         end
         if (bus.hi !== e.hi) begin
            failures++;
            $display("FAIL arith%0d_hi got=%h want=%h", i, bus.hi, e.hi);
         end
         if (bus.lo !== e.lo) begin
            failures++;
            $display("FAIL arith%0d_lo got=%h want=%h", i, bus.lo, e.lo);
         end
         bus.hilo_sel = 1'b1;
         #1;
         if (bus.hilo_E !== e.hi) begin
            failures++;
            $display("FAIL arith%0d_hilo_E_hi got=%h want=%h",
                     i, bus.hilo_E, e.hi);
         end
         bus.hilo_sel = 1'b0;
         #1;
         if (bus.hilo_E !== e.lo) begin
            failures++;
            $display("FAIL arith%0d_hilo_E_lo got=%h want=%h",
                     i, bus.hilo_E, e.lo);
         end
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   n;
      bit   held;
      run_op(MTHI, 32'hA5A5_A5A5, 32'd0, n, held);
      e = sb.pop_front();
      run_op(MTLO, 32'hA5A5_A5A5, 32'd0, n, held);
      e = sb.pop_front();
      e.cyc = predict(DIV, 32'h0000_0042, 32'd0);
      e.hi  = m_hi;
      e.lo  = m_lo;
      sb.push_back(e);
      bus.start   = 1'b1;
      bus.op      = DIV;
      bus.rs_data = 32'h0000_0042;
      bus.rt_data = 32'd0;
      @(negedge clk);
      n = 0;
      while (bus.busy && n < 40) begin
         bus.start   = (n == 2) || (n == 4);
         bus.op      = (n == 4) ? MULT : MTHI;
         bus.rs_data = 32'hDEAD_BEEF;
         bus.rt_data = 32'd3;
         n++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      checks += 3;
      if (n !== e.cyc) begin
         failures++;
         $display("FAIL divzero_busy got=%0d want=%0d", n, e.cyc);
      end
      if (bus.hi !== e.hi) begin
         failures++;
         $display("FAIL divzero_hi got=%h want=%h", bus.hi, e.hi);
      end
      if (bus.lo !== e.lo) begin
         failures++;
         $display("FAIL divzero_lo got=%h want=%h", bus.lo, e.lo);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL ignored_start_busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_reset_midrun();
      bit ok;
      bus.start   = 1'b1;
      bus.op      = MULT;
      bus.rs_data = 32'd7;
      bus.rt_data = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL midrun_busy3 got=%b want=1", bus.busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      checks += 2;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL midrun_abort_busy got=%b want=0", bus.busy);
      end
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         failures++;
         $display("FAIL midrun_abort_hilo got=%h_%h want=0_0",
                  bus.hi, bus.lo);
      end
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midrun_late_write got=written want=none");
      end
   endtask

   task automatic test_random();
      exp_t        e;
      int          n;
      bit          held;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op(op, a, b, n, held);
         e = sb.pop_front();
         checks += 3;
         if (n !== e.cyc) begin
            failures++;
            $display("FAIL rand%0d_busy op=%0d got=%0d want=%0d",
                     i, op, n, e.cyc);
         end
         if (bus.hi !== e.hi) begin
            failures++;
            $display("FAIL rand%0d_hi op=%0d got=%h want=%h",
                     i, op, bus.hi, e.hi);
         end
         if (bus.lo !== e.lo) begin
            failures++;
            $display("FAIL rand%0d_lo op=%0d got=%h want=%h",
                     i, op, bus.lo, e.lo);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.op       = 3'd0;
      bus.rs_data  = 32'd0;
      bus.rt_data  = 32'd0;
      bus.hilo_sel = 1'b0;
      reset        = 1'b1;
      @(negedge clk);
      test_reset();
      test_arith();
      test_busy_ignore();
      test_reset_midrun();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  E-stage issue strobe; one-cycle pulse per instruction
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- hilo_sel  in  1  0 = LO, 1 = HI on hilo_E
- busy  out  1  multi-cycle operation in progress
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- hilo_E  out  32  combinational: hilo_sel ? hi : lo; feeds the E/M pipeline register

Function
REQ-003 The FSM SHALL have states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-004 In IDLE, start=1 with op in {MULT, MULTU, MADD, MSUB} SHALL latch operands and op, load cnt=5, and enter RUN.
REQ-005 In IDLE, start=1 with op in {DIV, DIVU} SHALL latch operands and op, load cnt=10, and enter RUN.
REQ-006 In IDLE, start=1 with MTHI or MTLO SHALL write rs_data to HI or LO at that clock edge; busy stays 0; no RUN entry.
REQ-007 busy SHALL be 1 exactly while in RUN, i.e. cycles T+1..T+5 (mult class) or T+1..T+10 (div class) after start at cycle T.
REQ-008 In RUN, cnt SHALL decrement each cycle; at the edge where cnt goes 1->0, hi and lo SHALL update and the state SHALL return to IDLE.
REQ-009 Results SHALL be readable on hi, lo and hilo_E in the first cycle busy is 0 again; before that, hi and lo SHALL hold their old values.
REQ-010 MULT/MULTU SHALL yield the 64-bit signed/unsigned product, HI = bits [63:32], LO = bits [31:0].
REQ-011 DIV/DIVU SHALL yield LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-012 Division by zero SHALL still run 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-013 start while busy=1 SHALL be ignored, including MTHI/MTLO; the hazard unit stalls E on busy | (start & mul/div op).
REQ-014 Operands SHALL be sampled only at the start edge; later changes on rs_data or rt_data SHALL not affect the result.

Reset
REQ-015 reset=1 SHALL force IDLE, cnt=0, busy=0, hi=0, lo=0, latched operands=0, and SHALL take priority over start.
REQ-016 reset asserted mid-RUN SHALL abort the operation; no result is written after reset deasserts.

Configuration
REQ-017 Macro MULDIV_MADD_EN: when defined, MADD/MSUB SHALL compute {HI,LO} +/- signed(rs*rt) modulo 2^64 with 5-cycle latency.
REQ-018 When MULDIV_MADD_EN is undefined, ops 110/111 SHALL be no-ops: no busy, no HI/LO change.

Verification
REQ-019 MULT rs=0xFFFFFFFE, rt=0x00000003 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-020 DIVU rs=100, rt=7 -> busy high 10 cycles, then LO=14, HI=2; DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-021 MTLO 0x12345678, hilo_sel=0 -> LO and hilo_E = 0x12345678 in the next cycle, busy never high.
REQ-022 DIV rt=0 with HI=LO=0xA5A5A5A5 -> busy high 10 cycles, HI and LO stay 0xA5A5A5A5; MTHI issued during busy -> HI unchanged.
REQ-023 MULT started, reset pulsed on the 3rd busy cycle -> busy=0, HI=LO=0 immediately after, and no later write.
REQ-024 With MULDIV_MADD_EN defined, HI=0, LO=0xFFFFFFFF, MADD 1*1 -> HI=1, LO=0; without the macro -> HI/LO unchanged.
